// File: rtl/eu_operand_cache.sv
// Write-once/read-once operand store; reads are registered (1-cycle), writes stall on a FULL entry or lost
// same-index arbitration (lowest channel wins). Build with EU_OPERAND_CACHE_BYPASS_EN to forward same-cycle writes to missing reads.
module eu_operand_cache #(
    parameter int DATA_WIDTH  = 16,
    parameter int LOG2_DEPTH  = 3,
    parameter int NUM_WR_CH   = 2,
    parameter int NUM_RD      = 2,
    parameter int LOG2_NUM_EU = 2,
    parameter int EU_IDX      = 0
) (
    input  logic                              i_clk,
    input  logic                              i_nrst,
    input  logic [NUM_WR_CH-1:0]              i_wr_valid,
    input  logic [NUM_WR_CH*LOG2_NUM_EU-1:0]  i_wr_eu_idx,
    input  logic [NUM_WR_CH*LOG2_DEPTH-1:0]   i_wr_reg_idx,
    input  logic [NUM_WR_CH*DATA_WIDTH-1:0]   i_wr_data,
    output logic [NUM_WR_CH-1:0]              o_wr_ready,
    input  logic [NUM_RD-1:0]                 i_rd_req,
    input  logic [NUM_RD*LOG2_DEPTH-1:0]      i_rd_idx,
    output logic [NUM_RD-1:0]                 o_rd_valid,
    output logic [NUM_RD*DATA_WIDTH-1:0]      o_rd_data,
    output logic [LOG2_DEPTH:0]               o_free_count,
    output logic                              o_err_misroute,
    input  logic                              i_err_clr
);
    localparam int DEPTH = 2 ** LOG2_DEPTH;
    localparam int CW    = LOG2_DEPTH + 1;
    localparam logic [LOG2_NUM_EU-1:0] EU_ID = LOG2_NUM_EU'(EU_IDX);

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [LOG2_DEPTH-1:0] idx_t;

    data_t                        data_q [DEPTH];
    data_t                        data_d [DEPTH];
    logic [DEPTH-1:0]             hbr_q, hbr_d;
    logic [NUM_RD-1:0]            rd_valid_q, rd_valid_d;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [CW-1:0]                free_cnt_q, free_cnt_d;
    logic                         err_q, err_d;

    idx_t                         wr_idx [NUM_WR_CH];
    data_t                        wr_dat [NUM_WR_CH];
    logic [NUM_WR_CH-1:0]         wr_match;
    logic [NUM_WR_CH-1:0]         wr_ready;
    logic                         misroute;
    idx_t                         rd_idx [NUM_RD];

    logic [DEPTH-1:0]             ent_wr, ent_rd;
    data_t                        ent_wdat [DEPTH];
`ifdef EU_OPERAND_CACHE_BYPASS_EN
    logic [DEPTH-1:0]             ent_byp;
`endif

    always_comb begin
        for (int c = 0; c < NUM_WR_CH; c++) begin
            wr_idx[c]   = i_wr_reg_idx[c*LOG2_DEPTH +: LOG2_DEPTH];
            wr_dat[c]   = i_wr_data[c*DATA_WIDTH +: DATA_WIDTH];
            wr_match[c] = (i_wr_eu_idx[c*LOG2_NUM_EU +: LOG2_NUM_EU] == EU_ID);
        end
        for (int p = 0; p < NUM_RD; p++) begin
            rd_idx[p] = i_rd_idx[p*LOG2_DEPTH +: LOG2_DEPTH];
        end
    end

    // Misrouted writes are always accepted so they cannot block the channel; only their flag survives.
    always_comb begin
        wr_ready = '0;
        misroute = 1'b0;
        ent_wr   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_wdat[i] = '0;
        end
        for (int c = 0; c < NUM_WR_CH; c++) begin
            if (!wr_match[c]) begin
                wr_ready[c] = 1'b1;
                misroute    = misroute | i_wr_valid[c];
            end else begin
                wr_ready[c] = hbr_q[wr_idx[c]];
                for (int k = 0; k < c; k++) begin
                    if (i_wr_valid[k] && wr_match[k] && (wr_idx[k] == wr_idx[c])) begin
                        wr_ready[c] = 1'b0;
                    end
                end
                if (i_wr_valid[c] && wr_ready[c]) begin
                    ent_wr[wr_idx[c]]   = 1'b1;
                    ent_wdat[wr_idx[c]] = wr_dat[c];
                end
            end
        end
    end

    always_comb begin
        rd_valid_d = '0;
        rd_data_d  = rd_data_q;
        ent_rd     = '0;
`ifdef EU_OPERAND_CACHE_BYPASS_EN
        ent_byp    = '0;
`endif
        for (int p = 0; p < NUM_RD; p++) begin
            if (i_rd_req[p] && !hbr_q[rd_idx[p]]) begin
                rd_valid_d[p]                          = 1'b1;
                rd_data_d[p*DATA_WIDTH +: DATA_WIDTH]  = data_q[rd_idx[p]];
                ent_rd[rd_idx[p]]                      = 1'b1;
            end
`ifdef EU_OPERAND_CACHE_BYPASS_EN
            else if (i_rd_req[p] && ent_wr[rd_idx[p]]) begin
                rd_valid_d[p]                          = 1'b1;
                rd_data_d[p*DATA_WIDTH +: DATA_WIDTH]  = ent_wdat[rd_idx[p]];
                ent_byp[rd_idx[p]]                     = 1'b1;
            end
`endif
        end
    end

    // A write only lands on an EMPTY entry and a read only consumes a FULL one, so the two never collide.
    always_comb begin
        free_cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            data_d[i] = ent_wr[i] ? ent_wdat[i] : data_q[i];
            hbr_d[i]  = hbr_q[i];
            if (ent_wr[i]) begin
                hbr_d[i] = 1'b0;
            end
`ifdef EU_OPERAND_CACHE_BYPASS_EN
            if (ent_byp[i]) begin
                hbr_d[i] = 1'b1;
            end
`endif
            if (ent_rd[i]) begin
                hbr_d[i] = 1'b1;
            end
            free_cnt_d = free_cnt_d + CW'(hbr_d[i]);
        end
        err_d = misroute ? 1'b1 : (i_err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            hbr_q      <= '1;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            rd_valid_q <= '0;
            rd_data_q  <= '0;
            free_cnt_q <= CW'(DEPTH);
            err_q      <= 1'b0;
        end else begin
            hbr_q      <= hbr_d;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            free_cnt_q <= free_cnt_d;
            err_q      <= err_d;
        end
    end

    assign o_wr_ready     = wr_ready;
    assign o_rd_valid     = rd_valid_q;
    assign o_rd_data      = rd_data_q;
    assign o_free_count   = free_cnt_q;
    assign o_err_misroute = err_q;

endmodule

// File: tb/tb_eu_operand_cache.sv
// Randomized and directed bench for eu_operand_cache against an entry-level behavioural model.
`timescale 1ns/1ps
module tb_eu_operand_cache;
    localparam int DW    = 16;
    localparam int LD    = 3;
    localparam int DEPTH = 8;
    localparam int NWR   = 2;
    localparam int NRD   = 2;
    localparam int LEU   = 2;

    logic                 i_clk = 1'b0;
    logic                 i_nrst = 1'b0;
    logic [NWR-1:0]       i_wr_valid;
    logic [NWR*LEU-1:0]   i_wr_eu_idx;
    logic [NWR*LD-1:0]    i_wr_reg_idx;
    logic [NWR*DW-1:0]    i_wr_data;
    logic [NWR-1:0]       o_wr_ready;
    logic [NRD-1:0]       i_rd_req;
    logic [NRD*LD-1:0]    i_rd_idx;
    logic [NRD-1:0]       o_rd_valid;
    logic [NRD*DW-1:0]    o_rd_data;
    logic [LD:0]          o_free_count;
    logic                 o_err_misroute;
    logic                 i_err_clr;

    always #5 i_clk = ~i_clk;

    eu_operand_cache #(
        .DATA_WIDTH(DW), .LOG2_DEPTH(LD), .NUM_WR_CH(NWR), .NUM_RD(NRD),
        .LOG2_NUM_EU(LEU), .EU_IDX(0)
    ) dut (
        .i_clk(i_clk), .i_nrst(i_nrst),
        .i_wr_valid(i_wr_valid), .i_wr_eu_idx(i_wr_eu_idx), .i_wr_reg_idx(i_wr_reg_idx),
        .i_wr_data(i_wr_data), .o_wr_ready(o_wr_ready),
        .i_rd_req(i_rd_req), .i_rd_idx(i_rd_idx), .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data),
        .o_free_count(o_free_count), .o_err_misroute(o_err_misroute), .i_err_clr(i_err_clr)
    );

    // Stimulus, one element per channel/port
    bit              wv  [NWR];
    logic [LEU-1:0]  weu [NWR];
    logic [LD-1:0]   widx[NWR];
    logic [DW-1:0]   wd  [NWR];
    bit              rq  [NRD];
    logic [LD-1:0]   ri  [NRD];
    bit              clr;

    assign i_wr_valid   = {wv[1], wv[0]};
    assign i_wr_eu_idx  = {weu[1], weu[0]};
    assign i_wr_reg_idx = {widx[1], widx[0]};
    assign i_wr_data    = {wd[1], wd[0]};
    assign i_rd_req     = {rq[1], rq[0]};
    assign i_rd_idx     = {ri[1], ri[0]};
    assign i_err_clr    = clr;

    // Reference model: which entries hold an unread value, and that value
    bit              m_full[DEPTH];
    logic [DW-1:0]   m_mem [DEPTH];
    bit              m_err;
    logic [NWR-1:0]  last_rdy;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        for (int c = 0; c < NWR; c++) begin
            wv[c] = 0; weu[c] = '0; widx[c] = '0; wd[c] = '0;
        end
        for (int p = 0; p < NRD; p++) begin
            rq[p] = 0; ri[p] = '0;
        end
        clr = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_full[i] = 0; m_mem[i] = '0;
        end
        m_err = 0;
    endtask

    // One clock: check combinational readies, predict, clock, check registered outputs.
    task automatic cycle();
        int            win [DEPTH];
        bit            cons[DEPTH];
        bit            byp [DEPTH];
        bit            ev  [NRD];
        logic [DW-1:0] ed  [NRD];
        bit            mis;
        bit            exp_rdy;
        int            nfree;
        #1;
        mis = 0;
        for (int i = 0; i < DEPTH; i++) begin
            win[i] = -1; cons[i] = 0; byp[i] = 0;
        end
        for (int c = 0; c < NWR; c++) begin
            if (wv[c] && weu[c] == 0 && win[widx[c]] < 0) win[widx[c]] = c;
        end
        for (int c = 0; c < NWR; c++) begin
            if (weu[c] != 0) begin
                exp_rdy = 1;
                if (wv[c]) mis = 1;
            end else begin
                exp_rdy = !m_full[widx[c]] && !(win[widx[c]] >= 0 && win[widx[c]] < c);
            end
            check_eq($sformatf("wr_ready[%0d]", c), 32'(o_wr_ready[c]), 32'(exp_rdy));
            last_rdy[c] = o_wr_ready[c];
        end
        for (int p = 0; p < NRD; p++) begin
            ev[p] = 0; ed[p] = '0;
            if (rq[p]) begin
                if (m_full[ri[p]]) begin
                    ev[p] = 1; ed[p] = m_mem[ri[p]]; cons[ri[p]] = 1;
                end
`ifdef EU_OPERAND_CACHE_BYPASS_EN
                else if (win[ri[p]] >= 0) begin
                    ev[p] = 1; ed[p] = wd[win[ri[p]]]; byp[ri[p]] = 1;
                end
`endif
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (win[i] >= 0 && !m_full[i]) begin
                m_mem[i]  = wd[win[i]];
                m_full[i] = !byp[i];
            end else if (cons[i]) begin
                m_full[i] = 0;
            end
        end
        if (mis) m_err = 1;
        else if (clr) m_err = 0;
        nfree = 0;
        for (int i = 0; i < DEPTH; i++) if (!m_full[i]) nfree++;
        @(posedge i_clk);
        #1;
        for (int p = 0; p < NRD; p++) begin
            check_eq($sformatf("rd_valid[%0d]", p), 32'(o_rd_valid[p]), 32'(ev[p]));
            if (ev[p]) check_eq($sformatf("rd_data[%0d]", p), 32'(o_rd_data[p*DW +: DW]), 32'(ed[p]));
        end
        check_eq("free_count", 32'(o_free_count), 32'(nfree));
        check_eq("err_misroute", 32'(o_err_misroute), 32'(m_err));
    endtask

    initial begin
        idle();
        model_reset();
        repeat (3) @(posedge i_clk);
        #1;
        check_eq("rst_rd_valid", 32'(o_rd_valid), 32'd0);
        check_eq("rst_rd_data", o_rd_data, 32'd0);
        check_eq("rst_free_count", 32'(o_free_count), 32'd8);
        check_eq("rst_err", 32'(o_err_misroute), 32'd0);
        @(negedge i_clk) i_nrst = 1'b1;
        @(posedge i_clk);
        #1;

        // Basic write then read
        idle(); wv[0] = 1; widx[0] = 3; wd[0] = 16'h00A5; cycle();
        check_eq("t1_rdy", 32'(last_rdy[0]), 32'd1);
        check_eq("t1_fc_wr", 32'(o_free_count), 32'd7);
        idle(); rq[0] = 1; ri[0] = 3; cycle();
        check_eq("t1_rv", 32'(o_rd_valid[0]), 32'd1);
        check_eq("t1_rd", 32'(o_rd_data[15:0]), 32'h00A5);
        check_eq("t1_fc_rd", 32'(o_free_count), 32'd8);

        // Second write to a FULL entry stalls until the read drains it
        idle(); wv[0] = 1; widx[0] = 3; wd[0] = 16'h0111; cycle();
        wd[0] = 16'h0222; cycle();
        check_eq("t2_stall", 32'(last_rdy[0]), 32'd0);
        rq[0] = 1; ri[0] = 3; cycle();
        check_eq("t2_stall_rd", 32'(last_rdy[0]), 32'd0);
        check_eq("t2_rd", 32'(o_rd_data[15:0]), 32'h0111);
        rq[0] = 0; cycle();
        check_eq("t2_accept", 32'(last_rdy[0]), 32'd1);
        idle(); rq[0] = 1; ri[0] = 3; cycle();
        check_eq("t2_rd2", 32'(o_rd_data[15:0]), 32'h0222);

        // Same-index write arbitration
        idle(); wv[0] = 1; widx[0] = 5; wd[0] = 16'h1111; wv[1] = 1; widx[1] = 5; wd[1] = 16'h2222; cycle();
        check_eq("t3_rdy0", 32'(last_rdy[0]), 32'd1);
        check_eq("t3_rdy1", 32'(last_rdy[1]), 32'd0);
        wv[0] = 0; rq[0] = 1; ri[0] = 5; cycle();
        check_eq("t3_rd", 32'(o_rd_data[15:0]), 32'h1111);
        rq[0] = 0; cycle();
        check_eq("t3_retry", 32'(last_rdy[1]), 32'd1);
        idle(); rq[1] = 1; ri[1] = 5; cycle();
        check_eq("t3_rd2", 32'(o_rd_data[31:16]), 32'h2222);

        // Dual read of one FULL entry, then read of an EMPTY entry
        idle(); wv[1] = 1; widx[1] = 2; wd[1] = 16'h0BEE; cycle();
        idle(); rq[0] = 1; ri[0] = 2; rq[1] = 1; ri[1] = 2; cycle();
        check_eq("t4_rv", 32'(o_rd_valid), 32'd3);
        check_eq("t4_rd", o_rd_data, 32'h0BEE_0BEE);
        check_eq("t4_fc", 32'(o_free_count), 32'd8);
        idle(); rq[0] = 1; ri[0] = 6; cycle();
        check_eq("t4_miss", 32'(o_rd_valid[0]), 32'd0);

        // Misroute flag, clear, and misroute winning over clear
        idle(); wv[0] = 1; weu[0] = 1; widx[0] = 4; wd[0] = 16'hDEAD; cycle();
        check_eq("t5_rdy", 32'(last_rdy[0]), 32'd1);
        check_eq("t5_err", 32'(o_err_misroute), 32'd1);
        check_eq("t5_fc", 32'(o_free_count), 32'd8);
        idle(); clr = 1; cycle();
        check_eq("t5_clr", 32'(o_err_misroute), 32'd0);
        idle(); wv[1] = 1; weu[1] = 2; clr = 1; cycle();
        check_eq("t5_win", 32'(o_err_misroute), 32'd1);
        idle(); clr = 1; cycle();

        // Read and write the same EMPTY entry together
        idle(); wv[0] = 1; widx[0] = 1; wd[0] = 16'h5A5A; rq[0] = 1; ri[0] = 1; cycle();
`ifdef EU_OPERAND_CACHE_BYPASS_EN
        check_eq("t6_byp_rv", 32'(o_rd_valid[0]), 32'd1);
        check_eq("t6_byp_rd", 32'(o_rd_data[15:0]), 32'h5A5A);
        check_eq("t6_byp_fc", 32'(o_free_count), 32'd8);
`else
        check_eq("t6_rv", 32'(o_rd_valid[0]), 32'd0);
        check_eq("t6_fc", 32'(o_free_count), 32'd7);
`endif
        idle(); rq[0] = 1; ri[0] = 1; cycle();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < NWR; c++) begin
                wv[c]   = ($urandom_range(0, 9) < 6);
                weu[c]  = ($urandom_range(0, 15) == 0) ? LEU'($urandom_range(1, 3)) : '0;
                widx[c] = LD'($urandom_range(0, DEPTH - 1));
                wd[c]   = DW'($urandom);
            end
            for (int p = 0; p < NRD; p++) begin
                rq[p] = ($urandom_range(0, 1) == 1);
                ri[p] = LD'($urandom_range(0, DEPTH - 1));
            end
            clr = ($urandom_range(0, 9) == 0);
            cycle();
        end

        // Asynchronous reset with a read valid, the error flag set and entries FULL
        idle(); wv[0] = 1; widx[0] = 0; wd[0] = 16'h1234; cycle();
        idle(); rq[0] = 1; ri[0] = 0; wv[0] = 1; weu[0] = 1; wv[1] = 1; widx[1] = 7; wd[1] = 16'h7777; cycle();
        check_eq("pre_rst_rv", 32'(o_rd_valid[0]), 32'd1);
        check_eq("pre_rst_err", 32'(o_err_misroute), 32'd1);
        idle();
        #2 i_nrst = 1'b0;
        #1;
        check_eq("mid_rst_rv", 32'(o_rd_valid), 32'd0);
        check_eq("mid_rst_rd", o_rd_data, 32'd0);
        check_eq("mid_rst_fc", 32'(o_free_count), 32'd8);
        check_eq("mid_rst_err", 32'(o_err_misroute), 32'd0);
        model_reset();
        @(negedge i_clk) i_nrst = 1'b1;
        @(posedge i_clk);
        #1;
        idle(); rq[0] = 1; ri[0] = 7; cycle();
        idle(); wv[0] = 1; widx[0] = 7; wd[0] = 16'hCAFE; cycle();
        idle(); rq[1] = 1; ri[1] = 7; cycle();
        check_eq("post_rst_rd", 32'(o_rd_data[31:16]), 32'hCAFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
